ips2l_pcie_apb_mux_v2_0: RTL and testbench



---
 rtl/ips2l_pcie_apb_mux_v2_0_pkg.sv | 43 ++++
 rtl/ips2l_pcie_apb_dec_v2_0.sv | 43 ++++
 rtl/ips2l_pcie_apb_mux_v2_0.sv | 233 +++++++++++++++++++++++
 tb/tb_ips2l_pcie_apb_mux_v2_0.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ips2l_pcie_apb_mux_v2_0_pkg.sv
// Shared definitions for the APB decoder/mux: FSM encoding, default error
// read data and the region-table priority decode helper.
// The decode helper works on tables padded to MAX_SLV entries of MAX_DW bits.
// Unused entries have zero mask and base, and they are excluded by num_slv.
package ips2l_pcie_apb_mux_v2_0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int MAX_SLV = 8;
  localparam int MAX_DW  = 16;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One-hot decode of a region field. When several entries match, the lowest
  // index wins. The scan runs downward and later matches overwrite earlier
  // ones, so the last match written belongs to the lowest index.
  function automatic logic [MAX_SLV-1:0] dec_onehot(
    input logic [MAX_DW-1:0]         field,
    input logic [MAX_SLV*MAX_DW-1:0] base,
    input logic [MAX_SLV*MAX_DW-1:0] mask,
    input int                        num_slv
  );
    logic [MAX_SLV-1:0] hit;
    hit = '0;
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if ((i < num_slv) &&
          ((field & mask[i*MAX_DW +: MAX_DW]) ==
           (base[i*MAX_DW +: MAX_DW] & mask[i*MAX_DW +: MAX_DW]))) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/ips2l_pcie_apb_dec_v2_0.sv
// Combinational region decoder. It maps the decoded address field to a
// one-hot slave vector with lowest-index priority and raises a flag when no
// slave matches. The caller passes only the decoded field, addr[DEC_MSB:DEC_LSB].
module ips2l_pcie_apb_dec_v2_0
  import ips2l_pcie_apb_mux_v2_0_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DEC_MSB = 15,
  parameter int DEC_LSB = 12,
  parameter logic [NUM_SLV*(DEC_MSB-DEC_LSB+1)-1:0] SLV_BASE = {4'h7, 4'h2, 4'h1, 4'h0},
  parameter logic [NUM_SLV*(DEC_MSB-DEC_LSB+1)-1:0] SLV_MASK = {4'hF, 4'hF, 4'hF, 4'hF}
) (
  input  logic [DEC_MSB-DEC_LSB:0] i_field,
  output logic [NUM_SLV-1:0]       o_hit,
  output logic                     o_no_hit
);

  localparam int DW = DEC_MSB - DEC_LSB + 1;

  logic [MAX_SLV*MAX_DW-1:0] base_pad;
  logic [MAX_SLV*MAX_DW-1:0] mask_pad;
  logic [MAX_DW-1:0]         field_pad;
  logic [MAX_SLV-1:0]        hit_all;

  // Re-pack the user tables into the fixed-stride layout the helper expects.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    base_pad = '0;
    mask_pad = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      for (int b = 0; b < DW; b++) begin
        base_pad[i*MAX_DW + b] = SLV_BASE[i*DW + b];
        mask_pad[i*MAX_DW + b] = SLV_MASK[i*DW + b];
      end
    end
  end

  assign field_pad = MAX_DW'(i_field);
  assign hit_all   = dec_onehot(field_pad, base_pad, mask_pad, NUM_SLV);
  assign o_hit     = hit_all[NUM_SLV-1:0];
  assign o_no_hit  = ~|hit_all;

endmodule

// File: rtl/ips2l_pcie_apb_mux_v2_0.sv
// APB-style 1:NUM_SLV decoder/mux with registered request, error response
// for unmapped addresses, and a sticky error status with a saturating count.
// Optional build macro IPS2L_PCIE_APB_MUX_TIMEOUT_EN adds an ACCESS timeout
// that aborts a stalled slave after TIMEOUT_CYC cycles. When the macro is not
// defined, ACCESS waits for the slave's ready indefinitely.
module ips2l_pcie_apb_mux_v2_0
  import ips2l_pcie_apb_mux_v2_0_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEC_MSB = 15,
  parameter int DEC_LSB = 12,
  parameter logic [NUM_SLV*(DEC_MSB-DEC_LSB+1)-1:0] SLV_BASE = {4'h7, 4'h2, 4'h1, 4'h0},
  parameter logic [NUM_SLV*(DEC_MSB-DEC_LSB+1)-1:0] SLV_MASK = {4'hF, 4'hF, 4'hF, 4'hF},
  parameter int TIMEOUT_CYC = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_p_sel,
  input  logic [DATA_W/8-1:0]       i_p_strb,
  input  logic [ADDR_W-1:0]         i_p_addr,
  input  logic [DATA_W-1:0]         i_p_wdata,
  input  logic                      i_p_ce,
  input  logic                      i_p_we,
  output logic                      o_p_rdy,
  output logic [DATA_W-1:0]         o_p_rdata,
  output logic                      o_p_err,
  output logic [NUM_SLV-1:0]        o_slv_p_sel,
  output logic [NUM_SLV-1:0]        o_slv_p_ce,
  output logic [DATA_W/8-1:0]       o_slv_p_strb,
  output logic [ADDR_W-1:0]         o_slv_p_addr,
  output logic [DATA_W-1:0]         o_slv_p_wdata,
  output logic                      o_slv_p_we,
  input  logic [NUM_SLV-1:0]        i_slv_p_rdy,
  input  logic [NUM_SLV*DATA_W-1:0] i_slv_p_rdata,
  input  logic                      i_err_clr,
  output logic                      o_err_sticky,
  output logic [7:0]                o_err_cnt
);

  localparam int SW = DATA_W / 8;

  state_e              state_q, state_d;
  logic [NUM_SLV-1:0]  hit_q, hit_d;
  logic [SW-1:0]       strb_q, strb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_SLV-1:0]  dec_hit;
  logic                dec_no_hit;
  logic                req;
  logic                rdy_hit;
  logic                tmo_hit;
  logic                acc_done;
  logic                acc_tmo;
  logic                err_evt;
  logic [DATA_W-1:0]   slv_rdata_sel;

  ips2l_pcie_apb_dec_v2_0 #(
    .NUM_SLV  (NUM_SLV),
    .DEC_MSB  (DEC_MSB),
    .DEC_LSB  (DEC_LSB),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .i_field  (i_p_addr[DEC_MSB:DEC_LSB]),
    .o_hit    (dec_hit),
    .o_no_hit (dec_no_hit)
  );

  // The master is sampled only in IDLE. Changes on the master bus during
  // ACCESS do not reach the slaves.
  assign req      = (state_q == ST_IDLE) && i_p_sel && i_p_ce;
  // Ready from slaves that are not selected is masked off.
  assign rdy_hit  = |(i_slv_p_rdy & hit_q);
  assign acc_done = (state_q == ST_ACCESS) && rdy_hit;
  // A ready that arrives in the expiry cycle counts as a normal completion.
  assign acc_tmo  = (state_q == ST_ACCESS) && !rdy_hit && tmo_hit;
  assign err_evt  = (req && dec_no_hit) || acc_tmo;

`ifdef IPS2L_PCIE_APB_MUX_TIMEOUT_EN
  localparam int             TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Count ACCESS cycles; the count returns to zero whenever ACCESS is left.
  always_comb begin
    tmo_d = '0;
    if ((state_q == ST_ACCESS) && (state_d == ST_ACCESS)) tmo_d = tmo_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Select the read data of the addressed slave. hit_q is one-hot or zero.
  always_comb begin
    slv_rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit_q[i]) slv_rdata_sel |= i_slv_p_rdata[i*DATA_W +: DATA_W];
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = dec_no_hit ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (acc_done || acc_tmo) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request capture, response capture and error status update.
  always_comb begin
    hit_d    = hit_q;
    strb_d   = strb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (req) begin
      hit_d   = dec_hit;
      strb_d  = i_p_strb;
      addr_d  = i_p_addr;
      wdata_d = i_p_wdata;
      we_d    = i_p_we;
      err_d   = dec_no_hit;
      rdata_d = dec_no_hit ? ERR_RDATA : '0;
    end

    if (acc_done) begin
      err_d   = 1'b0;
      rdata_d = we_q ? '0 : slv_rdata_sel;
    end else if (acc_tmo) begin
      err_d   = 1'b1;
      rdata_d = ERR_RDATA;
    end

    // A clear and a new error in the same cycle leave sticky set and the count at one.
    if (i_err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (err_evt) begin
      sticky_d = 1'b1;
      cnt_d    = i_err_clr ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    end
  end

  // Datapath and status registers.
  // NOTE: these are plain flops rather than storage arrays, and they are reset so every output is defined to be 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q    <= '0;
      strb_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hit_q    <= hit_d;
      strb_q   <= strb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // FSM outputs: slave strobes in ACCESS, a one-cycle completion in RESP.
  // The strobes decode from state_q, so an asynchronous reset drops them at once.
  always_comb begin
    o_slv_p_sel = '0;
    o_slv_p_ce  = '0;
    o_p_rdy     = 1'b0;
    o_p_rdata   = '0;
    o_p_err     = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        o_slv_p_sel = hit_q;
        o_slv_p_ce  = hit_q;
      end
      ST_RESP: begin
        o_p_rdy   = 1'b1;
        o_p_rdata = rdata_q;
        o_p_err   = err_q;
      end
      default: ;
    endcase
  end

  assign o_slv_p_strb  = strb_q;
  assign o_slv_p_addr  = addr_q;
  assign o_slv_p_wdata = wdata_q;
  assign o_slv_p_we    = we_q;
  assign o_err_sticky  = sticky_q;
  assign o_err_cnt     = cnt_q;

endmodule

// File: tb/tb_ips2l_pcie_apb_mux_v2_0.sv
// Bench for ips2l_pcie_apb_mux_v2_0: directed and randomized transactions
// checked against a region-table / error-count reference model.
module tb_ips2l_pcie_apb_mux_v2_0;

  localparam int          TMO       = 8;
  localparam logic [127:0] OVL_RDATA = 128'h3333_3333_2222_2222_1111_1111_0BAD_F00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p_sel, ovl_sel_i, p_ce, p_we, err_clr;
  logic [3:0]  p_strb;
  logic [15:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  slv_rdy;
  logic [127:0] slv_rdata;

  logic        rdy, err, s_we, sticky;
  logic [31:0] rdata, s_wdata;
  logic [3:0]  s_sel, s_ce, s_strb;
  logic [15:0] s_addr;
  logic [7:0]  cnt;

  logic        ovl_rdy, ovl_err, ovl_we, ovl_sticky;
  logic [31:0] ovl_rdata, ovl_wdata;
  logic [3:0]  ovl_sel, ovl_ce, ovl_strb;
  logic [15:0] ovl_addr;
  logic [7:0]  ovl_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int m_cnt   = 0;
  bit m_sticky = 1'b0;

  ips2l_pcie_apb_mux_v2_0 #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_p_sel(p_sel), .i_p_strb(p_strb),
    .i_p_addr(p_addr), .i_p_wdata(p_wdata), .i_p_ce(p_ce), .i_p_we(p_we),
    .o_p_rdy(rdy), .o_p_rdata(rdata), .o_p_err(err),
    .o_slv_p_sel(s_sel), .o_slv_p_ce(s_ce), .o_slv_p_strb(s_strb),
    .o_slv_p_addr(s_addr), .o_slv_p_wdata(s_wdata), .o_slv_p_we(s_we),
    .i_slv_p_rdy(slv_rdy), .i_slv_p_rdata(slv_rdata), .i_err_clr(err_clr),
    .o_err_sticky(sticky), .o_err_cnt(cnt)
  );

  // Slave 0 has an all-don't-care mask here, so it matches every address.
  ips2l_pcie_apb_mux_v2_0 #(.TIMEOUT_CYC(TMO), .SLV_MASK(16'hFFF0)) dut_ovl (
    .i_clk(clk), .i_rst_n(rst_n), .i_p_sel(ovl_sel_i), .i_p_strb(p_strb),
    .i_p_addr(p_addr), .i_p_wdata(p_wdata), .i_p_ce(p_ce), .i_p_we(p_we),
    .o_p_rdy(ovl_rdy), .o_p_rdata(ovl_rdata), .o_p_err(ovl_err),
    .o_slv_p_sel(ovl_sel), .o_slv_p_ce(ovl_ce), .o_slv_p_strb(ovl_strb),
    .o_slv_p_addr(ovl_addr), .o_slv_p_wdata(ovl_wdata), .o_slv_p_we(ovl_we),
    .i_slv_p_rdy(4'hF), .i_slv_p_rdata(OVL_RDATA), .i_err_clr(err_clr),
    .o_err_sticky(ovl_sticky), .o_err_cnt(ovl_cnt)
  );

  // Reference region table: nibbles 0,1,2,7 map to slaves 0..3, everything else is unmapped.
  function automatic int ref_decode(input logic [15:0] addr);
    int base [4] = '{0, 1, 2, 7};
    for (int i = 0; i < 4; i++) if (int'(addr[15:12]) == base[i]) return i;
    return -1;
  endfunction

  // One master transaction with a slave that raises ready on ACCESS cycle rdy_after (0 = never).
  task automatic do_xact(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int rdy_after, input logic [31:0] sdata,
                         input logic clr);
    int k, edges, acc, exp_edges;
    bit tmo, got, exp_err;
    logic [3:0]  oh;
    logic [31:0] exp_rdata;
    k  = ref_decode(addr);
    oh = (k < 0) ? 4'b0000 : 4'(1 << k);
`ifdef IPS2L_PCIE_APB_MUX_TIMEOUT_EN
    tmo = (k >= 0) && ((rdy_after == 0) || (rdy_after > TMO));
`else
    tmo = 1'b0;
`endif
    exp_err   = (k < 0) || tmo;
    exp_edges = (k < 0) ? 1 : (tmo ? TMO + 1 : rdy_after + 1);
    exp_rdata = exp_err ? 32'hDEAD_BEEF : (we ? 32'h0 : sdata);
    if (clr) begin m_cnt = 0; m_sticky = 1'b0; end
    if (exp_err) begin m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1; m_sticky = 1'b1; end

    @(negedge clk);
    p_sel = 1'b1; p_ce = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata; p_strb = strb;
    err_clr = clr; slv_rdy = 4'b0000;
    edges = 0; acc = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(negedge clk);
      edges++;
      err_clr = 1'b0;
      if (rdy === 1'b1) got = 1'b1;
      else begin
        acc++;
        n_total++;
        if ({s_sel, s_ce} !== {oh, oh})
          $display("FAIL strobe addr=%h cyc=%0d got sel=%b ce=%b exp=%b", addr, acc, s_sel, s_ce, oh);
        else n_pass++;
        n_total++;
        if ({s_strb, s_addr, s_wdata, s_we} !== {strb, addr, wdata, we})
          $display("FAIL shared_bus addr=%h got %h/%h/%h/%b exp %h/%h/%h/%b",
                   addr, s_strb, s_addr, s_wdata, s_we, strb, addr, wdata, we);
        else n_pass++;
        // Master wanders during ACCESS; other slaves raise stray ready.
        p_addr = 16'($urandom); p_wdata = $urandom; p_we = 1'($urandom); p_strb = 4'($urandom);
        slv_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (k >= 0) slv_rdata[k*32 +: 32] = sdata;
        slv_rdy = 4'($urandom) & ~oh;
        if (acc == rdy_after) slv_rdy = slv_rdy | oh;
      end
    end
    n_total++;
    if (!got) $display("FAIL no_completion addr=%h got no rdy within %0d cycles exp %0d", addr, edges, exp_edges);
    else begin
      n_pass++;
      n_total++;
      if (edges != exp_edges) $display("FAIL latency addr=%h got=%0d exp=%0d", addr, edges, exp_edges);
      else n_pass++;
      n_total++;
      if ({err, rdata} !== {exp_err, exp_rdata})
        $display("FAIL response addr=%h we=%b got err=%b rdata=%h exp err=%b rdata=%h",
                 addr, we, err, rdata, exp_err, exp_rdata);
      else n_pass++;
      n_total++;
      if ({s_sel, s_ce} !== 8'h00) $display("FAIL resp_strobe addr=%h got sel=%b ce=%b exp 0", addr, s_sel, s_ce);
      else n_pass++;
      n_total++;
      if ({sticky, cnt} !== {m_sticky, 8'(m_cnt)})
        $display("FAIL err_status addr=%h got sticky=%b cnt=%0d exp sticky=%b cnt=%0d", addr, sticky, cnt, m_sticky, m_cnt);
      else n_pass++;
    end
    p_sel = 1'b0; p_ce = 1'b0; slv_rdy = 4'b0000;
    @(negedge clk);
    n_total++;
    if (rdy !== 1'b0) $display("FAIL rdy_pulse addr=%h got rdy=%b after completion exp 0", addr, rdy);
    else n_pass++;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if (|{rdy, rdata, err, s_sel, s_ce, s_strb, s_addr, s_wdata, s_we, sticky, cnt} !== 1'b0)
      $display("FAIL reset_main got rdy=%b sel=%b addr=%h cnt=%0d exp all 0", rdy, s_sel, s_addr, cnt);
    else n_pass++;
    n_total++;
    if (|{ovl_rdy, ovl_rdata, ovl_err, ovl_sel, ovl_ce, ovl_strb, ovl_addr, ovl_wdata, ovl_we, ovl_sticky, ovl_cnt} !== 1'b0)
      $display("FAIL reset_ovl got rdy=%b sel=%b exp all 0", ovl_rdy, ovl_sel);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mapped();
    do_xact(1'b1, 16'h7010, 32'h1234_5678, 4'hF, 2, $urandom, 1'b0);
    do_xact(1'b0, 16'h1004, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b0);
    do_xact(1'b0, 16'h0FFC, 32'h0, 4'h0, 3, 32'h0000_A5A5, 1'b0);
  endtask

  task automatic test_unmapped();
    do_xact(1'b0, 16'hA000, 32'h0, 4'h0, 1, 32'h0, 1'b0);
    do_xact(1'b1, 16'h3FFF, 32'h5555_AAAA, 4'h3, 1, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef IPS2L_PCIE_APB_MUX_TIMEOUT_EN
    do_xact(1'b0, 16'h2000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    do_xact(1'b0, 16'h2000, 32'h0, 4'h0, TMO, 32'h1357_9BDF, 1'b0);
`else
    do_xact(1'b0, 16'h2000, 32'h0, 4'h0, TMO + 4, 32'h1357_9BDF, 1'b0);
`endif
  endtask

  task automatic test_err_clr();
    do_xact(1'b0, 16'hB000, 32'h0, 4'h0, 1, 32'h0, 1'b1);
    do_xact(1'b0, 16'h1000, 32'h0, 4'h0, 1, 32'h2468_ACE0, 1'b1);
  endtask

  task automatic test_overlap();
    logic [15:0] a;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 16'hA000 : 16'($urandom);
      @(negedge clk);
      ovl_sel_i = 1'b1; p_ce = 1'b1; p_we = 1'b0; p_addr = a;
      @(negedge clk);
      n_total++;
      if (ovl_sel !== 4'b0001) $display("FAIL overlap_sel addr=%h got %b exp 0001", a, ovl_sel);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({ovl_rdy, ovl_err, ovl_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D})
        $display("FAIL overlap_resp addr=%h got rdy=%b err=%b rdata=%h exp 1/0/0badf00d", a, ovl_rdy, ovl_err, ovl_rdata);
      else n_pass++;
      ovl_sel_i = 1'b0; p_ce = 1'b0;
    end
  endtask

  task automatic test_reset_in_access();
    @(negedge clk);
    p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b0; p_addr = 16'h2000; slv_rdy = 4'b0000;
    @(negedge clk);
    n_total++;
    if (s_sel !== 4'b0100) $display("FAIL pre_reset_sel got %b exp 0100", s_sel);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (|{rdy, rdata, err, s_sel, s_ce, s_strb, s_addr, s_wdata, s_we, sticky, cnt} !== 1'b0)
      $display("FAIL async_reset got sel=%b ce=%b rdy=%b cnt=%0d exp all 0", s_sel, s_ce, rdy, cnt);
    else n_pass++;
    m_cnt = 0; m_sticky = 1'b0;
    p_sel = 1'b0; p_ce = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({rdy, s_sel} !== 5'b0) $display("FAIL reset_hold got rdy=%b sel=%b exp 0", rdy, s_sel);
    else n_pass++;
    rst_n = 1'b1;
    do_xact(1'b0, 16'h2040, 32'h0, 4'h0, 2, 32'h5A5A_0002, 1'b0);
  endtask

  task automatic test_random();
    int nib_tab [4] = '{0, 1, 2, 7};
    logic [3:0] nib;
    int ra;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 4);
      nib = (ra < 4) ? 4'(nib_tab[ra]) : 4'($urandom_range(8, 15));
      ra = $urandom_range(1, 6);
`ifdef IPS2L_PCIE_APB_MUX_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 1) * (TMO + 1);
`endif
      do_xact(1'($urandom), {nib, 12'($urandom)}, $urandom, 4'($urandom), ra, $urandom,
              1'($urandom_range(0, 9) == 0));
    end
  endtask

  task automatic test_saturation();
    do_xact(1'b0, 16'h8000, 32'h0, 4'h0, 1, 32'h0, 1'b1);
    for (int i = 0; i < 257; i++) do_xact(1'($urandom), {4'($urandom_range(3, 6)), 12'($urandom)}, $urandom, 4'hF, 1, 32'h0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no end of test exp finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    p_sel = 1'b0; ovl_sel_i = 1'b0; p_ce = 1'b0; p_we = 1'b0; err_clr = 1'b0;
    p_strb = '0; p_addr = '0; p_wdata = '0; slv_rdy = '0; slv_rdata = '0;
    test_reset();
    test_mapped();
    test_unmapped();
    test_timeout();
    test_err_clr();
    test_overlap();
    test_reset_in_access();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
